// File: rtl/lsu.sv
// Load/store unit: takes the ALU result as effective address and runs one
// request/grant/response transaction at a time on the data-memory port.
module lsu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            load_i,
    input  logic            store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_wstrb_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_data_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [7:0] strobe_f(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   strobe_f = 8'h01 << off;
            2'b01:   strobe_f = 8'h03 << off;
            2'b10:   strobe_f = 8'h0F << off;
            default: strobe_f = 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned_f(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b01:   misaligned_f = off[0];
            2'b10:   misaligned_f = |off[1:0];
            2'b11:   misaligned_f = |off[2:0];
            default: misaligned_f = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_fmt_f(input logic [XLEN-1:0] rdata,
                                                   input logic [2:0] f3,
                                                   input logic [2:0] off);
        logic [XLEN-1:0] r;
        r = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_fmt_f = {{56{r[7]}}, r[7:0]};
            3'b001:  load_fmt_f = {{48{r[15]}}, r[15:0]};
            3'b010:  load_fmt_f = {{32{r[31]}}, r[31:0]};
            3'b100:  load_fmt_f = {56'd0, r[7:0]};
            3'b101:  load_fmt_f = {48'd0, r[15:0]};
            3'b110:  load_fmt_f = {32'd0, r[31:0]};
            default: load_fmt_f = r;
        endcase
    endfunction

    state_t            state_r, state_next_s;
    logic              store_r, store_next_s;
    logic [2:0]        funct3_r, funct3_next_s;
    logic [2:0]        off_r, off_next_s;
    logic              mem_req_r, mem_req_next_s;
    logic              mem_we_r, mem_we_next_s;
    logic [XLEN-1:0]   mem_addr_r, mem_addr_next_s;
    logic [XLEN-1:0]   mem_wdata_r, mem_wdata_next_s;
    logic [7:0]        mem_wstrb_r, mem_wstrb_next_s;
    logic              out_valid_r, out_valid_next_s;
    logic [XLEN-1:0]   out_data_r, out_data_next_s;
    logic              misalign_r, misalign_next_s;
    logic              reserved_s;

    assign in_ready_o  = (state_r == IDLE) & ~rst;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign mem_wstrb_o = mem_wstrb_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign misalign_o  = misalign_r;

    // Reserved size encodings: 111 for loads, anything with bit 2 set for stores.
    assign reserved_s = load_i ? (funct3_i == 3'b111) : funct3_i[2];

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        state_next_s     = state_r;
        store_next_s     = store_r;
        funct3_next_s    = funct3_r;
        off_next_s       = off_r;
        mem_req_next_s   = mem_req_r;
        mem_we_next_s    = mem_we_r;
        mem_addr_next_s  = mem_addr_r;
        mem_wdata_next_s = mem_wdata_r;
        mem_wstrb_next_s = mem_wstrb_r;
        out_valid_next_s = out_valid_r;
        out_data_next_s  = out_data_r;
        misalign_next_s  = misalign_r;
        case (state_r)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    store_next_s  = store_i;
                    funct3_next_s = funct3_i;
                    off_next_s    = addr_i[2:0];
                    if (!(load_i || store_i)) begin
                        state_next_s     = DONE;
                        out_valid_next_s = 1'b1;
                        out_data_next_s  = addr_i;
                        misalign_next_s  = 1'b0;
                    end else if (reserved_s || misaligned_f(funct3_i[1:0], addr_i[2:0])) begin
                        state_next_s     = DONE;
                        out_valid_next_s = 1'b1;
                        out_data_next_s  = addr_i;
                        misalign_next_s  = 1'b1;
                    end else begin
                        state_next_s     = REQ;
                        mem_req_next_s   = 1'b1;
                        mem_we_next_s    = store_i;
                        mem_addr_next_s  = {addr_i[XLEN-1:3], 3'b000};
                        mem_wdata_next_s = store_i ? (wdata_i << {addr_i[2:0], 3'b000}) : {XLEN{1'b0}};
                        mem_wstrb_next_s = store_i ? strobe_f(funct3_i[1:0], addr_i[2:0]) : 8'h00;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    mem_req_next_s   = 1'b0;
                    mem_we_next_s    = 1'b0;
                    mem_wstrb_next_s = 8'h00;
                    if (store_r) begin
                        state_next_s     = DONE;
                        out_valid_next_s = 1'b1;
                        out_data_next_s  = {XLEN{1'b0}};
                        misalign_next_s  = 1'b0;
                    end else begin
                        state_next_s = WAIT;
                    end
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_next_s     = DONE;
                    out_valid_next_s = 1'b1;
                    out_data_next_s  = load_fmt_f(mem_rdata_i, funct3_r, off_r);
                    misalign_next_s  = 1'b0;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_next_s     = IDLE;
                    out_valid_next_s = 1'b0;
                    misalign_next_s  = 1'b0;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s     = IDLE;
                mem_req_next_s   = 1'b0;
                out_valid_next_s = 1'b0;
                misalign_next_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            store_r     <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 3'b000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            mem_wstrb_r <= 8'h00;
            out_valid_r <= 1'b0;
            out_data_r  <= {XLEN{1'b0}};
            misalign_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            store_r     <= store_next_s;
            funct3_r    <= funct3_next_s;
            off_r       <= off_next_s;
            mem_req_r   <= mem_req_next_s;
            mem_we_r    <= mem_we_next_s;
            mem_addr_r  <= mem_addr_next_s;
            mem_wdata_r <= mem_wdata_next_s;
            mem_wstrb_r <= mem_wstrb_next_s;
            out_valid_r <= out_valid_next_s;
            out_data_r  <= out_data_next_s;
            misalign_r  <= misalign_next_s;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: linear steps with immediate assertions.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        load_i;
    logic        store_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_data_o;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;

    lsu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for the accept cycle, then drop in_valid.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        chk("in_ready_before_accept", {63'd0, in_ready_o}, 64'd1);
        in_valid_i = 1'b1;
        load_i = ld; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
        tick();
        in_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    endtask

    task automatic handshake();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("out_valid_after_hs", {63'd0, out_valid_o}, 64'd0);
        chk("in_ready_after_hs", {63'd0, in_ready_o}, 64'd1);
    endtask

    // Load with grant in cycle 1, rvalid after rv_delay idle WAIT cycles, then hold.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] rdata, input logic [63:0] exp, input int rv_delay,
                           input int hold);
        issue(1'b0 | 1'b1, 1'b0, f3, a, 64'd0);
        chk({tag, "_req"}, {63'd0, mem_req_o}, 64'd1);
        chk({tag, "_we"}, {63'd0, mem_we_o}, 64'd0);
        chk({tag, "_wstrb"}, {56'd0, mem_wstrb_o}, {56'd0, 8'h00});
        chk({tag, "_maddr"}, mem_addr_o, {a[63:3], 3'b000});
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk({tag, "_req_wait"}, {63'd0, mem_req_o}, 64'd0);
        for (int i = 0; i < rv_delay; i++) begin
            tick();
            chk({tag, "_nvalid_wait"}, {63'd0, out_valid_o}, 64'd0);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rdata;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 64'd0;
        chk({tag, "_valid"}, {63'd0, out_valid_o}, 64'd1);
        chk({tag, "_data"}, out_data_o, exp);
        chk({tag, "_mis"}, {63'd0, misalign_o}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, {63'd0, out_valid_o}, 64'd1);
            chk({tag, "_hold_data"}, out_data_o, exp);
            chk({tag, "_hold_inready"}, {63'd0, in_ready_o}, 64'd0);
        end
        handshake();
    endtask

    // Instruction that must complete at cycle 1 with misalign set and no request.
    task automatic do_bad(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] a);
        issue(ld, st, f3, a, 64'hFFFF);
        chk({tag, "_req"}, {63'd0, mem_req_o}, 64'd0);
        chk({tag, "_valid"}, {63'd0, out_valid_o}, 64'd1);
        chk({tag, "_mis"}, {63'd0, misalign_o}, 64'd1);
        chk({tag, "_data"}, out_data_o, a);
        handshake();
    endtask

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0; funct3_i = 3'b000;
        addr_i = 64'd0; wdata_i = 64'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0;
        out_ready_i = 1'b0;
        #12;
        chk("rst_req", {63'd0, mem_req_o}, 64'd0);
        chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_inready", {63'd0, in_ready_o}, 64'd0);
        chk("rst_data", out_data_o, 64'd0);
        chk("rst_maddr", mem_addr_o, 64'd0);
        rst = 1'b0;
        tick();

        // ALU pass-through
        issue(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0);
        chk("alu_valid", {63'd0, out_valid_o}, 64'd1);
        chk("alu_data", out_data_o, 64'h1234);
        chk("alu_mis", {63'd0, misalign_o}, 64'd0);
        chk("alu_req", {63'd0, mem_req_o}, 64'd0);
        chk("alu_inready", {63'd0, in_ready_o}, 64'd0);
        handshake();

        // sh with three cycles of grant stall
        issue(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'hABCD);
        for (int i = 0; i < 4; i++) begin
            chk("sh_req", {63'd0, mem_req_o}, 64'd1);
            chk("sh_we", {63'd0, mem_we_o}, 64'd1);
            chk("sh_addr", mem_addr_o, 64'h8000_0000);
            chk("sh_wstrb", {56'd0, mem_wstrb_o}, {56'd0, 8'hC0});
            chk("sh_wdata", mem_wdata_o, 64'hABCD_0000_0000_0000);
            chk("sh_nvalid", {63'd0, out_valid_o}, 64'd0);
            if (i == 3) mem_gnt_i = 1'b1;
            else mem_gnt_i = 1'b0;
            tick();
        end
        mem_gnt_i = 1'b0;
        chk("sh_req_after", {63'd0, mem_req_o}, 64'd0);
        chk("sh_valid", {63'd0, out_valid_o}, 64'd1);
        chk("sh_data", out_data_o, 64'd0);
        chk("sh_mis", {63'd0, misalign_o}, 64'd0);
        handshake();

        // sw byte-lane strobes and data shift
        issue(1'b0, 1'b1, 3'b010, 64'h100C, 64'h1122_3344_5566_7788);
        chk("sw_wstrb", {56'd0, mem_wstrb_o}, {56'd0, 8'hF0});
        chk("sw_wdata", mem_wdata_o, 64'h5566_7788_0000_0000);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("sw_valid", {63'd0, out_valid_o}, 64'd1);
        handshake();

        // Loads: sign/zero extension, lane selection, backpressure, rvalid stall
        do_load("lb", 3'b000, 64'h8000_0003, 64'h0000_0000_F000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 0, 4);
        do_load("lbu", 3'b100, 64'h8000_0003, 64'h0000_0000_F000_0000, 64'h0000_0000_0000_00F0, 0, 0);
        do_load("ld", 3'b011, 64'h8000_0000, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 2, 0);
        do_load("lh", 3'b001, 64'h8000_0002, 64'h0000_0000_F000_0000, 64'hFFFF_FFFF_FFFF_F000, 0, 0);
        do_load("lw", 3'b010, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 0, 0);
        do_load("lwu", 3'b110, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 0, 0);

        // Misaligned and reserved encodings
        do_bad("lw_mis", 1'b1, 1'b0, 3'b010, 64'h8000_0002);
        do_bad("l111", 1'b1, 1'b0, 3'b111, 64'h8000_0000);
        do_bad("s100", 1'b0, 1'b1, 3'b100, 64'h8000_0000);
        do_bad("sd_mis", 1'b0, 1'b1, 3'b011, 64'h8000_0004);

        // Reset while in REQ drops the request at once
        issue(1'b1, 1'b0, 3'b011, 64'h8000_0000, 64'd0);
        chk("rreq_req", {63'd0, mem_req_o}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rreq_req_drop", {63'd0, mem_req_o}, 64'd0);
        chk("rreq_inready", {63'd0, in_ready_o}, 64'd0);
        #1 rst = 1'b0;
        tick();

        // Reset in WAIT; late rvalid must be ignored
        issue(1'b1, 1'b0, 3'b011, 64'h8000_0000, 64'd0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rwait_req", {63'd0, mem_req_o}, 64'd0);
        chk("rwait_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rwait_mis", {63'd0, misalign_o}, 64'd0);
        #1 rst = 1'b0;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 64'hDEAD_BEEF;
        tick();
        mem_rvalid_i = 1'b0;
        chk("late_rvalid_valid", {63'd0, out_valid_o}, 64'd0);
        tick();
        chk("late_rvalid_valid2", {63'd0, out_valid_o}, 64'd0);
        issue(1'b0, 1'b0, 3'b000, 64'h55AA, 64'd0);
        chk("post_rst_valid", {63'd0, out_valid_o}, 64'd1);
        chk("post_rst_data", out_data_o, 64'h55AA);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute-stage `alu`. It accepts one instruction per handshake from execute, uses the ALU result as the effective address, and runs a single-outstanding request/grant/response transaction on the data-memory port. Loads are byte-lane aligned and sign/zero extended. Stores get byte strobes generated. Non-memory instructions pass their ALU result through with one cycle of latency, so writeback always sees a uniform valid/ready stream.

## Interface
- `XLEN`, 64, datapath width; fixed at 64, which gives 8 byte lanes.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid_i` in 1: execute holds a valid instruction.
- `in_ready_o` out 1: the unit accepts an instruction; equals `(state==IDLE) & ~rst`.
- `load_i` in 1: load opinfo bit.
- `store_i` in 1: store opinfo bit; never asserted together with `load_i`.
- `funct3_i` in 3: size and sign encoding.
- `addr_i` in XLEN: ALU `res_o`; the effective address, or the result for non-memory instructions.
- `wdata_i` in XLEN: store data (rs2).
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = write.
- `mem_addr_o` out XLEN: `{addr[XLEN-1:3], 3'b000}`.
- `mem_wdata_o` out XLEN: store data shifted left by `addr[2:0]*8`.
- `mem_wstrb_o` out 8: byte strobes; all zero for loads.
- `mem_gnt_i` in 1: request accepted.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in XLEN: read data, 8-byte aligned.
- `out_valid_o` out 1: result available to writeback.
- `out_ready_i` in 1: writeback consumes the result.
- `out_data_o` out XLEN: load data, passed-through ALU result, or 0 for stores.
- `misalign_o` out 1: qualifies `out_valid_o`; flags a misaligned access or a reserved `funct3`.

## Operation
- States:
  - IDLE: waiting for an instruction.
  - REQ: memory request asserted.
  - WAIT: load issued, waiting for read data.
  - DONE: result held for writeback.
- Accept: `in_valid_i & in_ready_o`. On accept, latch `load`, `store`, `funct3`, `addr` and `wdata` into internal registers.
- From IDLE on accept:
  - Neither `load` nor `store`: go to DONE with `out_data = addr_i`.
  - `funct3` reserved (loads: 111; stores: 1xx): go to DONE with `misalign_o = 1` and `out_data = addr_i`.
  - Misaligned: go to DONE with `misalign_o = 1` and `out_data = addr_i`. Alignment is checked against the access size: h requires `addr[0]==0`; w requires `addr[1:0]==0`; d requires `addr[2:0]==0`. No memory request is issued.
  - Otherwise: go to REQ.
- REQ:
  - `mem_req_o = 1`; address, data, strobe and write-enable outputs are stable until grant.
  - On `mem_gnt_i`, a store goes to DONE with `out_data = 0`.
  - On `mem_gnt_i`, a load goes to WAIT.
- WAIT: on `mem_rvalid_i`, capture the formatted data and go to DONE. `mem_rvalid_i` is ignored in every state except WAIT.
- DONE: `out_valid_o = 1`; on `out_ready_i`, go to IDLE.
- Strobes, with `o = addr[2:0]`:
  - b: `8'h01 << o`
  - h: `8'h03 << o`
  - w: `8'h0F << o`
  - d: `8'hFF`
- Load formatting:
  - `r = mem_rdata_i >> (o*8)`.
  - lb/lh/lw sign-extend from bit 7/15/31.
  - lbu/lhu/lwu zero-extend.
  - ld takes `r` as is.
- Reset state: IDLE; all registered outputs 0 (`mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wstrb_o`, `out_valid_o`, `out_data_o`, `misalign_o`).

## Timing
- Accept occurs at cycle 0 (edge at the end of cycle 0).
- ALU pass-through, misaligned and reserved cases: `out_valid_o` at cycle 1.
- Store: `mem_req_o` at cycle 1; with grant in cycle 1, `out_valid_o` at cycle 2.
- Load: request at cycle 1, grant at cycle 1, earliest `mem_rvalid_i` at cycle 2, `out_valid_o` at cycle 3.
- Each cycle without grant adds one cycle; likewise each cycle without `rvalid`.
- Back-to-back: `in_ready_o` rises in the cycle after the DONE handshake. Throughput is at most one instruction per 2 cycles.
- `out_valid_o`, `out_data_o` and `misalign_o` stay stable while `out_ready_i == 0`.
- Only one transaction is ever outstanding; `mem_req_o` is never asserted in WAIT or DONE.
- Reset mid-transaction (REQ or WAIT):
  - `mem_req_o` and `out_valid_o` drop immediately, because reset is asynchronous.
  - The state returns to IDLE.
  - A late `mem_rvalid_i` after reset is ignored.

## Test plan
- ALU pass-through: `addr_i = 64'h1234`, no load/store → `out_valid_o` at cycle 1, `out_data_o = 64'h1234`, `misalign_o = 0`, `mem_req_o` never asserted.
- `sh`: `addr_i = 64'h8000_0006`, `wdata_i = 64'hABCD` → `mem_addr_o = 64'h8000_0000`, `mem_wstrb_o = 8'hC0`, `mem_wdata_o[63:48] = 16'hABCD`. Hold grant low for 3 cycles → `mem_req_o` held with stable outputs; `out_valid_o` 1 cycle after grant, `out_data_o = 0`.
- `lb` vs `lbu`: `addr_i = 64'h8000_0003`, `mem_rdata_i = 64'h0000_0000_F000_0000`.
  - `lb` → `out_data_o = 64'hFFFF_FFFF_FFFF_FFF0`.
  - `lbu` → `out_data_o = 64'hF0`.
  - `ld` at `64'h8000_0000` → the full word.
- Misaligned: `lw` at `64'h8000_0002` → no `mem_req_o`; `out_valid_o` at cycle 1 with `misalign_o = 1` and `out_data_o = 64'h8000_0002`. Same behaviour for load `funct3 = 111`.
- Backpressure: hold `out_ready_i = 0` for 4 cycles after a load completes → `out_valid_o`/`out_data_o` stable and `in_ready_o = 0` throughout; `in_ready_o = 1` in the cycle after the handshake.
- Reset mid-load: assert `rst` in WAIT → `mem_req_o`, `out_valid_o` and `misalign_o` = 0 immediately. A `mem_rvalid_i` pulse after `rst` deasserts produces no `out_valid_o`; the next instruction is accepted normally.
